// File: rtl/uart_ddr_pkg.sv
// Shared definitions for the UART <-> DDR byte/word path.
//
// Contents:
//   BYTE_W, WORD_W  - default byte and storage word widths
//   ST_IDLE/ST_SEND - state encodings shared by packetizer/depacketizer FSMs
//   num_slices()    - number of OUT_W slices in an IN_W word
//   idx_width()     - width of a slice index register (never below 1 bit)
package uart_ddr_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  function automatic int unsigned num_slices(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/depacketizer.sv
// Splits wide words from the read-side FIFO into a serial byte stream for the UART TX.
// Slice order matches the packetizer so a packetize/store/depacketize round trip
// reproduces the original byte sequence.
//
// Ports:
//   i_clk    - clock
//   i_rst    - synchronous active-high reset; discards any partially sent word
//   i_valid  - upstream word valid
//   i_data   - upstream word, taken when i_valid && o_ready
//   o_ready  - word can be accepted this cycle (combinational, independent of i_valid)
//   o_data   - registered output byte
//   o_valid  - registered output byte valid
//   i_ready  - downstream accepts the byte this cycle
//   o_busy   - a word is in flight
module depacketizer
  import uart_ddr_pkg::*;
#(
  parameter int unsigned IN_W      = WORD_W,
  parameter int unsigned OUT_W     = BYTE_W,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy
);

  localparam int unsigned N     = num_slices(IN_W, OUT_W);
  localparam int unsigned IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((IN_W % OUT_W) != 0 || N < 2) begin : g_bad_width
    $error("depacketizer: IN_W must be a multiple of OUT_W with at least two slices");
  end

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IN_W-1:0]  shift_q, shift_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic             last_slice;
  logic             handshake;
  logic [IN_W-1:0]  shift_next;

  // The slice to emit always sits at the "front" end of the shift register, so
  // the output mux is fixed and only the shift direction depends on MSB_FIRST.
  function automatic logic [OUT_W-1:0] front_slice(input logic [IN_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[IN_W-1 -: OUT_W];
    end else begin
      return w[OUT_W-1:0];
    end
  endfunction

  assign shift_next = (MSB_FIRST != 0) ? (shift_q << OUT_W) : (shift_q >> OUT_W);
  assign last_slice = (idx_q == LAST_IDX);
  assign handshake  = valid_q && i_ready;

  // Ready on the final slice only when that slice is actually leaving, which
  // lets the next word load on the same edge with no bubble.
  assign o_ready = (state_q == ST_IDLE) || ((state_q == ST_SEND) && last_slice && i_ready);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          shift_d = i_data;
          data_d  = front_slice(i_data);
          idx_d   = '0;
        end
      end

      ST_SEND: begin
        if (handshake) begin
          if (!last_slice) begin
            shift_d = shift_next;
            data_d  = front_slice(shift_next);
            idx_d   = idx_q + IDX_W'(1);
          end else if (i_valid) begin
            shift_d = i_data;
            data_d  = front_slice(i_data);
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q == ST_SEND);

endmodule
